// File: rtl/reel_sequencer.sv
// reel_sequencer: three-reel slot animation controller.
// A single start spins all reels. Each reel accelerates, cruises, decelerates
// at a staggered point, then creeps to the next symbol boundary and stops.
// Motion advances only on tick cycles. Offsets carry over between spins.
module reel_sequencer #(
   parameter int STRIP_H    = 240,
   parameter int SYM_H      = 80,
   parameter int MAX_SPD    = 3,
   parameter int ACC_TICKS  = 60,
   parameter int HOLD_TICKS = 240,
   parameter int STAGGER    = 120
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start_dn,
   input  logic       start_up,
   output logic [9:0] a_off,
   output logic [9:0] b_off,
   output logic [9:0] c_off,
   output logic       busy,
   output logic       done,
   output logic [1:0] sym_a,
   output logic [1:0] sym_b,
   output logic [1:0] sym_c
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_FINISH  = 2'd2;

   localparam logic [2:0] P_ACCEL   = 3'd0;
   localparam logic [2:0] P_CRUISE  = 3'd1;
   localparam logic [2:0] P_DECEL   = 3'd2;
   localparam logic [2:0] P_SNAP    = 3'd3;
   localparam logic [2:0] P_STOPPED = 3'd4;

   localparam logic [9:0]  SYM_W    = 10'(SYM_H);
   localparam logic [10:0] STRIP_W  = 11'(STRIP_H);
   localparam logic [2:0]  MAX_W    = 3'(MAX_SPD);
   localparam logic [15:0] ACC_LAST = 16'(ACC_TICKS - 1);

   // Tick count at which reel r starts decelerating.
   function automatic logic [15:0] decel_point(input int r);
      return 16'(HOLD_TICKS + r * STAGGER);
   endfunction

   logic [1:0]  state;
   logic        dir;              // 0: offsets increase, 1: offsets decrease
   logic [15:0] tcnt;
   logic [15:0] acnt;             // ticks since start, modulo ACC_TICKS
   logic [9:0]  off     [3];
   logic [2:0]  spd     [3];
   logic [2:0]  ph      [3];
   logic [15:0] dcnt    [3];      // ticks since DECEL entry, modulo ACC_TICKS
   logic [1:0]  sym     [3];

   logic [15:0] tnext;
   logic        acc_wrap;
   logic        all_stopped;
   logic [9:0]  off_nx  [3];
   logic [2:0]  spd_nx  [3];
   logic [2:0]  ph_nx   [3];
   logic [15:0] dcnt_nx [3];
   logic [2:0]  mv      [3];
   logic [10:0] sum     [3];
   logic        at_sym  [3];

   // Next per-reel motion/phase state for a tick in RUN; movement uses the current speed.
   always_comb begin
      tnext       = tcnt + 16'd1;
      acc_wrap    = (acnt == ACC_LAST);
      all_stopped = (ph[0] == P_STOPPED) && (ph[1] == P_STOPPED) && (ph[2] == P_STOPPED);
      for (int r = 0; r < 3; r++) begin
         at_sym[r]  = ((off[r] % SYM_W) == 10'd0);
         spd_nx[r]  = spd[r];
         ph_nx[r]   = ph[r];
         dcnt_nx[r] = dcnt[r];
         mv[r]      = 3'd0;
         case (ph[r])
            P_ACCEL: begin
               mv[r] = spd[r];
               if (tnext == decel_point(r)) begin
                  ph_nx[r]   = P_DECEL;
                  dcnt_nx[r] = 16'd0;
               end else if (acc_wrap) begin
                  spd_nx[r] = spd[r] + 3'd1;
                  if (spd_nx[r] == MAX_W) begin
                     ph_nx[r] = P_CRUISE;
                  end else begin
                     ph_nx[r] = P_ACCEL;
                  end
               end else begin
                  ph_nx[r] = P_ACCEL;
               end
            end
            P_CRUISE: begin
               mv[r] = spd[r];
               if (tnext == decel_point(r)) begin
                  ph_nx[r]   = P_DECEL;
                  dcnt_nx[r] = 16'd0;
               end else begin
                  ph_nx[r] = P_CRUISE;
               end
            end
            P_DECEL: begin
               mv[r] = spd[r];
               if (spd[r] == 3'd1) begin
                  ph_nx[r] = P_SNAP;
               end else if (dcnt[r] == ACC_LAST) begin
                  spd_nx[r]  = spd[r] - 3'd1;
                  dcnt_nx[r] = 16'd0;
                  ph_nx[r]   = (spd_nx[r] == 3'd1) ? P_SNAP : P_DECEL;
               end else begin
                  dcnt_nx[r] = dcnt[r] + 16'd1;
               end
            end
            P_SNAP: begin
               if (at_sym[r]) begin
                  spd_nx[r] = 3'd0;
                  ph_nx[r]  = P_STOPPED;
                  mv[r]     = 3'd0;
               end else begin
                  mv[r] = 3'd1;
               end
            end
            default: begin
               mv[r] = 3'd0;
            end
         endcase
         // Wrap the displacement onto the strip in either direction.
         sum[r] = {1'b0, off[r]} + {8'd0, mv[r]};
         if (!dir) begin
            off_nx[r] = (sum[r] >= STRIP_W) ? 10'(sum[r] - STRIP_W) : sum[r][9:0];
         end else if (off[r] < {7'd0, mv[r]}) begin
            off_nx[r] = 10'(STRIP_W - 11'({8'd0, mv[r]}) + {1'b0, off[r]});
         end else begin
            off_nx[r] = off[r] - {7'd0, mv[r]};
         end
      end
   end

   // Global sequencing: start acceptance, tick-driven motion, finish pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         dir   <= 1'b0;
         tcnt  <= 16'd0;
         acnt  <= 16'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            off[r]  <= 10'd0;
            spd[r]  <= 3'd0;
            ph[r]   <= P_STOPPED;
            dcnt[r] <= 16'd0;
            sym[r]  <= 2'd0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start_dn || start_up) begin
                  state <= S_RUN;
                  dir   <= ~start_dn;
                  tcnt  <= 16'd0;
                  acnt  <= 16'd0;
                  busy  <= 1'b1;
                  for (int r = 0; r < 3; r++) begin
                     spd[r]  <= 3'd1;
                     ph[r]   <= P_ACCEL;
                     dcnt[r] <= 16'd0;
                  end
               end
            end
            S_RUN: begin
               if (all_stopped) begin
                  state <= S_FINISH;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  for (int r = 0; r < 3; r++) begin
                     sym[r] <= 2'(off[r] / SYM_W);
                  end
               end else if (tick) begin
                  tcnt <= tnext;
                  acnt <= acc_wrap ? 16'd0 : acnt + 16'd1;
                  for (int r = 0; r < 3; r++) begin
                     off[r]  <= off_nx[r];
                     spd[r]  <= spd_nx[r];
                     ph[r]   <= ph_nx[r];
                     dcnt[r] <= dcnt_nx[r];
                  end
               end
            end
            S_FINISH: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign a_off = off[0];
   assign b_off = off[1];
   assign c_off = off[2];
   assign sym_a = sym[0];
   assign sym_b = sym[1];
   assign sym_c = sym[2];

endmodule

// File: tb/tb_reel_sequencer.sv
// tb_reel_sequencer: drives reel_sequencer with directed and random stimulus
// and compares every output against a behavioural model of the spin rules.
module tb_reel_sequencer;

   localparam int STRIP = 240;
   localparam int SYM   = 80;
   localparam int MAXS  = 3;
   localparam int ACC   = 2;
   localparam int HOLD  = 16;
   localparam int STAG  = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       start_dn = 1'b0;
   logic       start_up = 1'b0;
   logic [9:0] a_off, b_off, c_off;
   logic       busy, done;
   logic [1:0] sym_a, sym_b, sym_c;
   logic [37:0] dv;

   int checks = 0;
   int errors = 0;

   // model state: ms 0 idle / 1 run / 2 finish; phase 0 accel .. 4 stopped
   int ms, mdir, mtcnt, mbusy, mdone;
   int moff [3];
   int mspd [3];
   int mph  [3];
   int mtdec[3];
   int msym [3];

   reel_sequencer #(
      .STRIP_H(STRIP), .SYM_H(SYM), .MAX_SPD(MAXS),
      .ACC_TICKS(ACC), .HOLD_TICKS(HOLD), .STAGGER(STAG)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .start_dn(start_dn), .start_up(start_up),
      .a_off(a_off), .b_off(b_off), .c_off(c_off), .busy(busy), .done(done),
      .sym_a(sym_a), .sym_b(sym_b), .sym_c(sym_c)
   );

   assign dv = {a_off, b_off, c_off, busy, done, sym_a, sym_b, sym_c};

   always #5 clk = ~clk;

   function automatic logic [37:0] exp_vec();
      return {10'(moff[0]), 10'(moff[1]), 10'(moff[2]), 1'(mbusy), 1'(mdone),
              2'(msym[0]), 2'(msym[1]), 2'(msym[2])};
   endfunction

   task automatic move(input int r, input int amount);
      if (mdir == 0) moff[r] = (moff[r] + amount) % STRIP;
      else           moff[r] = (moff[r] - amount + STRIP) % STRIP;
   endtask

   task automatic model_reel(input int r, input int t);
      int dp;
      dp = HOLD + r * STAG;
      case (mph[r])
         0: begin
            move(r, mspd[r]);
            if (t == dp) begin mph[r] = 2; mtdec[r] = t; end
            else if (t % ACC == 0) begin
               mspd[r]++;
               if (mspd[r] == MAXS) mph[r] = 1;
            end
         end
         1: begin
            move(r, mspd[r]);
            if (t == dp) begin mph[r] = 2; mtdec[r] = t; end
         end
         2: begin
            move(r, mspd[r]);
            if (mspd[r] == 1) mph[r] = 3;
            else if ((t - mtdec[r]) % ACC == 0) begin
               mspd[r]--;
               if (mspd[r] == 1) mph[r] = 3;
            end
         end
         3: begin
            if (moff[r] % SYM == 0) begin mspd[r] = 0; mph[r] = 4; end
            else move(r, 1);
         end
         default: ;
      endcase
   endtask

   task automatic model_edge();
      if (rst) begin
         ms = 0; mdir = 0; mtcnt = 0; mbusy = 0; mdone = 0;
         for (int r = 0; r < 3; r++) begin
            moff[r] = 0; mspd[r] = 0; mph[r] = 4; msym[r] = 0;
         end
      end else if (ms == 0) begin
         mdone = 0;
         if (start_dn || start_up) begin
            ms = 1; mdir = start_dn ? 0 : 1; mtcnt = 0; mbusy = 1;
            for (int r = 0; r < 3; r++) begin mspd[r] = 1; mph[r] = 0; end
         end
      end else if (ms == 1) begin
         if (mph[0] == 4 && mph[1] == 4 && mph[2] == 4) begin
            ms = 2; mdone = 1; mbusy = 0;
            for (int r = 0; r < 3; r++) msym[r] = moff[r] / SYM;
         end else if (tick) begin
            mtcnt++;
            for (int r = 0; r < 3; r++) model_reel(r, mtcnt);
         end
      end else begin
         mdone = 0; ms = 0;
      end
   endtask

   task automatic step(input logic t, input logic d, input logic u, input logic r);
      tick = t; start_dn = d; start_up = u; rst = r;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 1'b0, 1'b1);
      checks++;
      if (dv !== exp_vec() || a_off !== 10'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got=%h exp=%h", dv, exp_vec());
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         checks++;
         if (dv !== exp_vec() || {a_off, b_off, c_off} !== 30'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, dv, exp_vec());
         end
      end
   endtask

   task automatic test_accel();
      int seq[5];
      int ndone;
      bit fin;
      seq = '{1, 2, 4, 6, 9};
      ndone = 0; fin = 0;
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         checks++;
         if (a_off !== 10'(seq[i]) || dv !== exp_vec()) begin
            errors++;
            $display("FAIL accel_seq i=%0d a_off=%0d exp=%0d vec=%h model=%h", i, a_off, seq[i], dv, exp_vec());
         end
      end
      for (int c = 0; c < 1000 && !fin; c++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         checks++;
         if (dv !== exp_vec()) begin
            errors++;
            $display("FAIL accel_spin cyc=%0d got=%h exp=%h", c, dv, exp_vec());
         end
         if (done === 1'b1) begin
            ndone++;
            checks++;
            if ((a_off % 10'd80) !== 10'd0 || (b_off % 10'd80) !== 10'd0 || (c_off % 10'd80) !== 10'd0) begin
               errors++;
               $display("FAIL spin_snap offs=%0d,%0d,%0d exp multiples of 80", a_off, b_off, c_off);
            end
         end
         if (ms == 0 && ndone > 0) fin = 1;
      end
      checks++;
      if (ndone != 1 || !fin) begin
         errors++;
         $display("FAIL spin_done_count got=%0d exp=1 finished=%0d", ndone, fin);
      end
   endtask

   task automatic test_up();
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (a_off !== 10'd239 || c_off !== 10'd239 || dv !== exp_vec()) begin
         errors++;
         $display("FAIL up_first a_off=%0d exp=239 vec=%h model=%h", a_off, dv, exp_vec());
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (a_off !== 10'd238 || dv !== exp_vec()) begin
         errors++;
         $display("FAIL up_second a_off=%0d exp=238", a_off);
      end
   endtask

   task automatic test_both_and_ignore();
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (a_off !== 10'd1 || dv !== exp_vec()) begin
         errors++;
         $display("FAIL both_dir a_off=%0d exp=1", a_off);
      end
      step(1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (a_off !== 10'd2 || busy !== 1'b1 || dv !== exp_vec()) begin
         errors++;
         $display("FAIL ignore_up a_off=%0d busy=%0d exp a_off=2 busy=1", a_off, busy);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (a_off !== 10'd4 || dv !== exp_vec()) begin
         errors++;
         $display("FAIL ignore_up_dir a_off=%0d exp=4", a_off);
      end
   endtask

   task automatic test_random_spins();
      for (int s = 0; s < 3; s++) begin
         int ndone;
         bit fin;
         logic d, u;
         ndone = 0; fin = 0;
         while (ms != 0) step(1'b1, 1'b0, 1'b0, 1'b0);
         d = 1'($urandom_range(0, 1));
         u = ~d;
         step(1'b0, d, u, 1'b0);
         for (int c = 0; c < 3000 && !fin; c++) begin
            step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 9) == 0) && (ms != 0), 1'b0);
            checks++;
            if (dv !== exp_vec()) begin
               errors++;
               $display("FAIL rand_spin s=%0d cyc=%0d got=%h exp=%h", s, c, dv, exp_vec());
            end
            if (done === 1'b1) ndone++;
            if (ndone > 0 && ms == 0) fin = 1;
         end
         checks++;
         if (ndone != 1 || !fin) begin
            errors++;
            $display("FAIL rand_done s=%0d got=%0d exp=1 finished=%0d", s, ndone, fin);
         end
      end
   endtask

   task automatic test_rst_mid();
      int c;
      while (ms != 0) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      c = 0;
      while (mph[0] != 2 && c < 500) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         c++;
      end
      checks++;
      if (mph[0] != 2) begin
         errors++;
         $display("FAIL rst_mid_reach decel not reached after %0d cycles", c);
      end
      step(1'b1, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({a_off, b_off, c_off} !== 30'd0 || busy !== 1'b0 || done !== 1'b0 || dv !== exp_vec()) begin
         errors++;
         $display("FAIL rst_mid offs=%0d,%0d,%0d busy=%0d done=%0d exp all 0", a_off, b_off, c_off, busy, done);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || dv !== exp_vec()) begin
         errors++;
         $display("FAIL rst_restart busy=%0d exp=1", busy);
      end
   endtask

   initial begin
      ms = 0; mdir = 0; mtcnt = 0; mbusy = 0; mdone = 0;
      for (int r = 0; r < 3; r++) begin
         moff[r] = 0; mspd[r] = 0; mph[r] = 4; mtdec[r] = 0; msym[r] = 0;
      end
      #2;
      test_reset();
      test_accel();
      test_up();
      test_both_and_ignore();
      test_random_spins();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
